// File: rtl/cellrv32_bus_arbiter.sv
// ------------------------------------------------------------------------------------------------
// cellrv32_bus_arbiter
//
// Shares the processor-internal bus between two requesters with a single outstanding transfer.
//   Port A: CPU data port (read/write).
//   Port B: i-cache block-download port (read-only).
// Request pulses are buffered, so a pulse that arrives while the bus is busy is served later.
// An optional watchdog turns a hung WAIT phase into an error towards the granted port.
//
// Ports
//   clk_i, rstn_i          clock (rising edge), asynchronous active-low reset
//   a_*_i / a_*_o          port A request (addr, wdata, ben, re/we pulses) and response
//   b_*_i / b_*_o          port B request (addr, re pulse, cached flag) and response
//   bus_src_o              grant owner (0 = A, 1 = B)
//   bus_cached_o           b_cached_i while B owns an active transfer
//   bus_addr/wdata/ben_o   muxed request fields, following the grant register
//   bus_re_o / bus_we_o    one-cycle bus strobes
//   bus_rdata/ack/err_i    bus response
// ------------------------------------------------------------------------------------------------
module cellrv32_bus_arbiter #(
    parameter bit          PORT_A_PRIO = 1'b1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    // port A: CPU data port
    input  logic [31:0] a_addr_i,
    input  logic [31:0] a_wdata_i,
    input  logic [3:0]  a_ben_i,
    input  logic        a_re_i,
    input  logic        a_we_i,
    output logic [31:0] a_rdata_o,
    output logic        a_ack_o,
    output logic        a_err_o,
    // port B: instruction / cache download port
    input  logic [31:0] b_addr_i,
    input  logic        b_re_i,
    input  logic        b_cached_i,
    output logic [31:0] b_rdata_o,
    output logic        b_ack_o,
    output logic        b_err_o,
    // shared bus
    output logic        bus_src_o,
    output logic        bus_cached_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_ben_o,
    output logic        bus_re_o,
    output logic        bus_we_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CntW-1:0] CntMax      = {CntW{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;          // 0 = A, 1 = B
    logic              granted_once_q, granted_once_d;
    logic              rw_q, rw_d;                // current transfer is a write
    logic              a_req_buf_q, a_req_buf_d;
    logic              a_rw_buf_q, a_rw_buf_d;
    logic              b_req_buf_q, b_req_buf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic a_pulse;
    logic pend_a;
    logic pend_b;
    logic grant_sel;
    logic xfer_ack;
    logic xfer_err;
    logic active;

    assign a_pulse = a_re_i | a_we_i;
    assign pend_a  = a_pulse | a_req_buf_q;
    assign pend_b  = b_re_i | b_req_buf_q;

    // Grant resolution for the IDLE state. In round-robin mode the tie goes to the port that was
    // not granted last; before any grant has happened there is no "last" port, so A wins.
    always_comb begin
        grant_sel = 1'b0;
        if (pend_a && pend_b) begin
            if (PORT_A_PRIO) begin
                grant_sel = 1'b0;
            end else if (granted_once_q) begin
                grant_sel = ~grant_q;
            end else begin
                grant_sel = 1'b0;
            end
        end else begin
            grant_sel = ~pend_a;
        end
    end

    // Next-state, buffering and strobes.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        granted_once_d = granted_once_q;
        rw_d           = rw_q;
        cnt_d          = cnt_q;
        a_req_buf_d    = a_req_buf_q | a_pulse;
        a_rw_buf_d     = a_pulse ? a_we_i : a_rw_buf_q;  // re+we together counts as a write
        b_req_buf_d    = b_req_buf_q | b_re_i;
        bus_re_o       = 1'b0;
        bus_we_o       = 1'b0;
        xfer_ack       = 1'b0;
        xfer_err       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pend_a || pend_b) begin
                    grant_d        = grant_sel;
                    granted_once_d = 1'b1;
                    state_d        = StReq;
                    if (!grant_sel) begin
                        a_req_buf_d = 1'b0;
                        rw_d        = a_pulse ? a_we_i : a_rw_buf_q;
                    end else begin
                        b_req_buf_d = 1'b0;
                        rw_d        = 1'b0;
                    end
                end
            end

            StReq: begin
                bus_re_o = ~rw_q;
                bus_we_o = rw_q;
                cnt_d    = '0;
                state_d  = StWait;
            end

            StWait: begin
                if (bus_ack_i) begin
                    xfer_ack = 1'b1;
                    state_d  = StIdle;
                end else if (bus_err_i) begin
                    xfer_err = 1'b1;
                    state_d  = StIdle;
                end else begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    if ((TIMEOUT != 0) && (cnt_q == TimeoutLast)) begin
                        xfer_err = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= StIdle;
            grant_q        <= 1'b0;
            granted_once_q <= 1'b0;
            rw_q           <= 1'b0;
            a_req_buf_q    <= 1'b0;
            a_rw_buf_q     <= 1'b0;
            b_req_buf_q    <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            granted_once_q <= granted_once_d;
            rw_q           <= rw_d;
            a_req_buf_q    <= a_req_buf_d;
            a_rw_buf_q     <= a_rw_buf_d;
            b_req_buf_q    <= b_req_buf_d;
            cnt_q          <= cnt_d;
        end
    end

    // Response routing: only the granted port ever sees ack/err/rdata.
    assign active       = (state_q == StReq) || (state_q == StWait);
    assign a_ack_o      = xfer_ack & ~grant_q;
    assign a_err_o      = xfer_err & ~grant_q;
    assign b_ack_o      = xfer_ack & grant_q;
    assign b_err_o      = xfer_err & grant_q;
    assign a_rdata_o    = a_ack_o ? bus_rdata_i : 32'h0;
    assign b_rdata_o    = b_ack_o ? bus_rdata_i : 32'h0;

    assign bus_src_o    = grant_q;
    assign bus_cached_o = active & grant_q & b_cached_i;
    assign bus_addr_o   = grant_q ? b_addr_i : a_addr_i;
    assign bus_wdata_o  = grant_q ? 32'h0 : a_wdata_i;
    assign bus_ben_o    = grant_q ? 4'hF : a_ben_i;

endmodule

// File: tb/tb_cellrv32_bus_arbiter.sv
// Directed bench: fixed-priority instance (TIMEOUT=8) plus a round-robin instance.
module tb_cellrv32_bus_arbiter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // fixed-priority instance signals
    logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, bus_rdata = '0;
    logic [3:0]  a_ben = '0;
    logic        a_re = 0, a_we = 0, b_re = 0, b_cached = 0, bus_ack = 0, bus_err = 0;
    logic [31:0] a_rdata, b_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_ben;
    logic        a_ack, a_err, b_ack, b_err, bus_src, bus_cached, bus_re, bus_we;
    logic [5:0]  flags;
    assign flags = {a_ack, a_err, b_ack, b_err, bus_re, bus_we};

    // round-robin instance signals
    logic [31:0] r_a_addr = 32'h0000_A000, r_b_addr = 32'h0000_B000, r_bus_rdata = 32'h1111_2222;
    logic        r_a_re = 0, r_b_re = 0, r_b_cached = 1, r_bus_ack = 1;
    logic [31:0] r_a_rdata, r_b_rdata, r_bus_addr, r_bus_wdata;
    logic [3:0]  r_bus_ben;
    logic        r_a_ack, r_a_err, r_b_ack, r_b_err, r_bus_src, r_bus_cached, r_bus_re, r_bus_we;
    logic [5:0]  r_flags;
    assign r_flags = {r_a_ack, r_a_err, r_b_ack, r_b_err, r_bus_re, r_bus_we};

    cellrv32_bus_arbiter #(.PORT_A_PRIO(1'b1), .TIMEOUT(8)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_ben_i(a_ben), .a_re_i(a_re), .a_we_i(a_we),
        .a_rdata_o(a_rdata), .a_ack_o(a_ack), .a_err_o(a_err),
        .b_addr_i(b_addr), .b_re_i(b_re), .b_cached_i(b_cached),
        .b_rdata_o(b_rdata), .b_ack_o(b_ack), .b_err_o(b_err),
        .bus_src_o(bus_src), .bus_cached_o(bus_cached), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_ben_o(bus_ben), .bus_re_o(bus_re), .bus_we_o(bus_we),
        .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack), .bus_err_i(bus_err)
    );

    cellrv32_bus_arbiter #(.PORT_A_PRIO(1'b0), .TIMEOUT(8)) dut_rr (
        .clk_i(clk), .rstn_i(rstn),
        .a_addr_i(r_a_addr), .a_wdata_i(32'h0), .a_ben_i(4'hF), .a_re_i(r_a_re), .a_we_i(1'b0),
        .a_rdata_o(r_a_rdata), .a_ack_o(r_a_ack), .a_err_o(r_a_err),
        .b_addr_i(r_b_addr), .b_re_i(r_b_re), .b_cached_i(r_b_cached),
        .b_rdata_o(r_b_rdata), .b_ack_o(r_b_ack), .b_err_o(r_b_err),
        .bus_src_o(r_bus_src), .bus_cached_o(r_bus_cached), .bus_addr_o(r_bus_addr),
        .bus_wdata_o(r_bus_wdata), .bus_ben_o(r_bus_ben), .bus_re_o(r_bus_re),
        .bus_we_o(r_bus_we),
        .bus_rdata_i(r_bus_rdata), .bus_ack_i(r_bus_ack), .bus_err_i(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and drop all one-cycle pulses.
    task automatic cyc();
        @(posedge clk);
        #1;
        a_re = 0; a_we = 0; b_re = 0; bus_ack = 0; bus_err = 0;
    endtask

    initial begin
        // ---------------- reset ----------------
        #2;
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_src", 32'(bus_src), 32'h0);
        chk("rst_rdata", a_rdata | b_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rstn = 1;

        // ---------------- A read, ack two cycles after strobe ----------------
        cyc();
        a_addr = 32'h0000_1000; a_ben = 4'b0011; a_re = 1;
        #1 chk("rd_idle", 32'(flags), 32'h0);
        cyc();
        #1 chk("rd_strobe", 32'(flags), 32'b000010);
        chk("rd_addr", bus_addr, 32'h0000_1000);
        chk("rd_ben", 32'(bus_ben), 32'h3);
        cyc();
        #1 chk("rd_wait", 32'(flags), 32'h0);
        cyc();
        bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
        #1 chk("rd_ack", 32'(flags), 32'b100000);
        chk("rd_rdata", a_rdata, 32'hDEAD_BEEF);
        chk("rd_b_rdata", b_rdata, 32'h0);
        cyc();
        #1 chk("rd_done", 32'(flags), 32'h0);
        chk("rd_rdata_clr", a_rdata, 32'h0);

        // ---------------- A write + B read in the same cycle ----------------
        cyc();
        a_addr = 32'h0000_2000; a_wdata = 32'h1234_5678; a_ben = 4'hC; a_we = 1;
        b_addr = 32'h0000_3000; b_cached = 1; b_re = 1;
        #1 chk("wb_idle", 32'(flags), 32'h0);
        cyc();
        #1 chk("wb_a_strobe", 32'(flags), 32'b000001);
        chk("wb_a_src", 32'(bus_src), 32'h0);
        chk("wb_a_wdata", bus_wdata, 32'h1234_5678);
        chk("wb_a_ben", 32'(bus_ben), 32'hC);
        chk("wb_a_cached", 32'(bus_cached), 32'h0);
        cyc();
        bus_ack = 1;
        #1 chk("wb_a_ack", 32'(flags), 32'b100000);
        cyc();
        #1 chk("wb_gap", 32'(flags), 32'h0);
        cyc();
        #1 chk("wb_b_strobe", 32'(flags), 32'b000010);
        chk("wb_b_src", 32'(bus_src), 32'h1);
        chk("wb_b_addr", bus_addr, 32'h0000_3000);
        chk("wb_b_wdata", bus_wdata, 32'h0);
        chk("wb_b_ben", 32'(bus_ben), 32'hF);
        chk("wb_b_cached", 32'(bus_cached), 32'h1);
        cyc();
        bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
        #1 chk("wb_b_ack", 32'(flags), 32'b001000);
        chk("wb_b_rdata", b_rdata, 32'hCAFE_F00D);
        chk("wb_a_rdata0", a_rdata, 32'h0);
        cyc();
        #1 chk("wb_done", 32'(flags), 32'h0);
        chk("wb_cached_off", 32'(bus_cached), 32'h0);
        cyc();
        #1 chk("wb_no_repeat", 32'(flags), 32'h0);

        // ---------------- B pulse while A waits, then bus error on B ----------------
        b_cached = 0;
        cyc();
        a_addr = 32'h0000_4000; a_re = 1;
        cyc();
        #1 chk("bf_a_strobe", 32'(flags), 32'b000010);
        cyc();
        b_addr = 32'h0000_5000; b_re = 1;
        #1 chk("bf_a_wait", 32'(flags), 32'h0);
        cyc();
        bus_ack = 1;
        #1 chk("bf_a_ack", 32'(flags), 32'b100000);
        cyc();
        #1 chk("bf_gap", 32'(flags), 32'h0);
        cyc();
        #1 chk("bf_b_strobe", 32'(flags), 32'b000010);
        chk("bf_b_addr", bus_addr, 32'h0000_5000);
        chk("bf_b_cached", 32'(bus_cached), 32'h0);
        cyc();
        bus_err = 1;
        #1 chk("bf_b_err", 32'(flags), 32'b000100);
        cyc();
        #1 chk("bf_done", 32'(flags), 32'h0);

        // ---------------- stray response in IDLE ----------------
        cyc();
        bus_ack = 1; bus_err = 1; bus_rdata = 32'h5555_AAAA;
        #1 chk("stray_flags", 32'(flags), 32'h0);
        chk("stray_rdata", a_rdata | b_rdata, 32'h0);

        // ---------------- watchdog: bus never answers ----------------
        cyc();
        a_addr = 32'h0000_6000; a_re = 1;
        cyc();
        #1 chk("to_strobe", 32'(flags), 32'b000010);
        for (int i = 0; i < 7; i++) begin
            cyc();
            #1 chk("to_wait", 32'(flags), 32'h0);
        end
        cyc();
        #1 chk("to_err", 32'(flags), 32'b010000);
        cyc();
        bus_ack = 1;
        #1 chk("to_late_ack", 32'(flags), 32'h0);
        cyc();
        #1 chk("to_idle", 32'(flags), 32'h0);

        // ---------------- reset during B WAIT ----------------
        cyc();
        b_addr = 32'h0000_7000; b_cached = 1; b_re = 1;
        cyc();
        #1 chk("rs_b_strobe", 32'(flags), 32'b000010);
        cyc();
        #1 chk("rs_b_cached", 32'(bus_cached), 32'h1);
        rstn = 0; bus_ack = 1;
        #1 chk("rs_flags", 32'(flags), 32'h0);
        chk("rs_src", 32'(bus_src), 32'h0);
        chk("rs_cached", 32'(bus_cached), 32'h0);
        chk("rs_rdata", b_rdata, 32'h0);
        cyc();
        rstn = 1; bus_ack = 1;
        #1 chk("rs_after_rel", 32'(flags), 32'h0);
        cyc();
        bus_ack = 1;
        #1 chk("rs_late_ack", 32'(flags), 32'h0);
        b_cached = 0;

        // ---------------- round robin with continuous requests ----------------
        cyc();
        r_a_re = 1; r_b_re = 1;
        for (int i = 0; i < 4; i++) begin
            logic is_b;
            is_b = (i % 2) == 1;
            #1 chk("rr_idle", 32'(r_flags), 32'h0);
            cyc();
            #1 chk("rr_strobe", 32'(r_flags), 32'b000010);
            chk("rr_src", 32'(r_bus_src), 32'(is_b));
            chk("rr_cached_req", 32'(r_bus_cached), 32'(is_b));
            chk("rr_addr", r_bus_addr, is_b ? 32'h0000_B000 : 32'h0000_A000);
            cyc();
            #1 chk("rr_ack", 32'(r_flags), is_b ? 32'b001000 : 32'b100000);
            chk("rr_cached_wait", 32'(r_bus_cached), 32'(is_b));
            chk("rr_b_rdata", r_b_rdata, is_b ? 32'h1111_2222 : 32'h0);
            cyc();
        end
        r_a_re = 0; r_b_re = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound in case something above stalls.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
